// File: rtl/lcd_linebuf.sv
// lcd_linebuf: PPU line-buffer scan converter with vertical line repeat.
// Stores PPU lines in a ring of LINES slots and replays each one VREP times
// on a free-running output raster that resyncs at every PPU frame start.
// Optional underrun detection is built when LCD_UNDERRUN_EN is defined.
module lcd_linebuf #(
    parameter int unsigned H     = 160,
    parameter int unsigned V     = 144,
    parameter int unsigned BPP   = 2,
    parameter int unsigned LINES = 4,
    parameter int unsigned VREP  = 4,
    parameter int unsigned HFP   = 16,
    parameter int unsigned HS    = 20,
    parameter int unsigned HBP   = 32,
    parameter int unsigned VFP   = 2,
    parameter int unsigned VS    = 2,
    parameter int unsigned VBP   = 36
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce_in,
    input  logic [BPP-1:0] din,
    input  logic [1:0]     mode,
    input  logic           ce_pix,
    input  logic           lcd_on,
    output logic           hs,
    output logic           vs,
    output logic           blank,
    output logic [BPP-1:0] pix,
    output logic           underrun
);

    localparam int unsigned HT   = H + HFP + HS + HBP;
    localparam int unsigned VT   = V * VREP + VFP + VS + VBP;
    localparam int unsigned VVIS = V * VREP;
    localparam int unsigned HW   = $clog2(HT);
    localparam int unsigned VW   = $clog2(VT);
    localparam int unsigned IW   = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned PW   = $clog2(H + 1);
    localparam int unsigned SW   = $clog2(VT + 1);
    localparam int unsigned RW   = (VREP > 1) ? $clog2(VREP) : 1;
    localparam int unsigned LB   = $clog2(LINES);
    localparam int unsigned WLW  = 8;

    localparam logic [1:0] MODE_HBLANK = 2'b00;
    localparam logic [1:0] MODE_VBLANK = 2'b01;

    logic [1:0]     r_prev_mode;
    logic [WLW-1:0] r_wl;
    logic [PW-1:0]  r_wp;
    logic [HW-1:0]  r_h_cnt;
    logic [VW-1:0]  r_v_cnt;
    logic [SW-1:0]  r_src;
    logic [RW-1:0]  r_rep;
    logic [BPP-1:0] r_rd_data;
    logic           r_hs;
    logic           r_vs;
    logic           r_blank;
    logic [BPP-1:0] r_pix;
    logic [BPP-1:0] r_mem [LINES][H];

    logic           w_frame_start;
    logic           w_line_start;
    logic           w_wr_en;
    logic [LB-1:0]  w_wr_slot;
    logic [IW-1:0]  w_wr_idx;
    logic [LB-1:0]  w_rd_slot;
    logic [IW-1:0]  w_rd_idx;
    logic           w_h_vis;
    logic           w_v_vis;
    logic           w_vis;
    logic           w_line_bad;

    assign w_frame_start = (mode != MODE_VBLANK) && (r_prev_mode == MODE_VBLANK);
    assign w_line_start  = (mode != MODE_HBLANK) && (r_prev_mode == MODE_HBLANK);
    assign w_wr_en       = reset_n && ce_in && (32'(r_wp) < H);
    assign w_wr_slot     = r_wl[LB-1:0];
    assign w_wr_idx      = r_wp[IW-1:0];

    assign w_h_vis   = 32'(r_h_cnt) < H;
    assign w_v_vis   = 32'(r_v_cnt) < VVIS;
    assign w_vis     = w_h_vis && w_v_vis;
    assign w_rd_slot = r_src[LB-1:0];
    assign w_rd_idx  = w_h_vis ? r_h_cnt[IW-1:0] : '0;

    // Mode edge detection, write line and write pointer; start events override the pointer step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev_mode <= MODE_VBLANK;
            r_wl        <= '0;
            r_wp        <= '0;
        end else begin
            r_prev_mode <= mode;
            if (w_frame_start) begin
                r_wl <= '0;
                r_wp <= '0;
            end else if (w_line_start) begin
                if (r_wl != {WLW{1'b1}}) begin
                    r_wl <= r_wl + WLW'(1);
                end
                r_wp <= '0;
            end else if (w_wr_en) begin
                r_wp <= r_wp + PW'(1);
            end
        end
    end

    // Buffer write port; a sample coincident with a start event uses the old slot and index
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_slot][w_wr_idx] <= din;
        end
    end

    // Synchronous buffer read, captured the clk after the raster moves
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[w_rd_slot][w_rd_idx];
    end

    // Output raster counters with source-line / repeat tracking and frame resync
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_src   <= '0;
            r_rep   <= '0;
        end else if (w_frame_start) begin
            r_h_cnt <= '0;
            r_v_cnt <= VW'(VT - VREP);
            r_src   <= SW'((VT - VREP) / VREP);
            r_rep   <= RW'((VT - VREP) % VREP);
        end else if (ce_pix) begin
            if (32'(r_h_cnt) == HT - 1) begin
                r_h_cnt <= '0;
                if (32'(r_v_cnt) == VT - 1) begin
                    r_v_cnt <= '0;
                    r_src   <= '0;
                    r_rep   <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + VW'(1);
                    if (32'(r_rep) == VREP - 1) begin
                        r_rep <= '0;
                        r_src <= r_src + SW'(1);
                    end else begin
                        r_rep <= r_rep + RW'(1);
                    end
                end
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

    // Registered video outputs for the raster position held before each pixel tick
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_blank <= 1'b1;
            r_pix   <= '0;
        end else if (ce_pix) begin
            r_hs    <= (32'(r_h_cnt) >= H + HFP) && (32'(r_h_cnt) < H + HFP + HS);
            r_vs    <= (32'(r_v_cnt) >= VVIS + VFP) && (32'(r_v_cnt) < VVIS + VFP + VS);
            r_blank <= !w_vis;
            r_pix   <= (w_vis && lcd_on && !w_line_bad) ? r_rd_data : '0;
        end
    end

`ifdef LCD_UNDERRUN_EN
    localparam int unsigned CW = (SW > WLW) ? SW : WLW;

    logic r_line_bad;
    logic r_underrun;
    logic w_bad_now;

    // Source line not yet complete, or its slot already reused by a newer line
    assign w_bad_now  = (CW'(r_src) >= CW'(r_wl)) ||
                        ((CW'(r_wl) - CW'(r_src)) >= CW'(LINES));
    assign w_line_bad = (r_h_cnt == '0) ? w_bad_now : r_line_bad;

    // Latch the per-line verdict at h=0 of visible lines and keep a sticky flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_line_bad <= 1'b0;
            r_underrun <= 1'b0;
        end else if (ce_pix && w_v_vis && (r_h_cnt == '0)) begin
            r_line_bad <= w_bad_now;
            if (w_bad_now) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign underrun = r_underrun;
`else
    assign w_line_bad = 1'b0;
    assign underrun   = 1'b0;
`endif

    assign hs    = r_hs;
    assign vs    = r_vs;
    assign blank = r_blank;
    assign pix   = r_pix;

endmodule

// File: tb/tb_lcd_linebuf.sv
// Bench for lcd_linebuf: directed PPU write sequences, an output-raster
// position tracker that captures one frame of outputs, and a vector table.
module tb_lcd_linebuf;

    localparam int unsigned H = 8, V = 4, BPP = 2, LINES = 4, VREP = 2;
    localparam int unsigned HFP = 2, HS = 2, HBP = 2, VFP = 1, VS = 1, VBP = 1;
    localparam int unsigned HT = H + HFP + HS + HBP;
    localparam int unsigned VT = V * VREP + VFP + VS + VBP;

    typedef struct {
        int         v;
        int         h;
        logic [1:0] pix;
        logic       blank;
        logic       hs;
        logic       vs;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           ce_in = 1'b0;
    logic [BPP-1:0] din = '0;
    logic [1:0]     mode = 2'b01;
    logic           ce_pix = 1'b0;
    logic           lcd_on = 1'b1;
    logic           hs, vs, blank, underrun;
    logic [BPP-1:0] pix;

    int checks = 0;
    int failures = 0;

    // Expected raster position held by the DUT counters
    int         mh = 0;
    int         mv = 0;
    logic [1:0] m_prev = 2'b01;
    logic       m_tick, m_rst, m_fs;
    logic [1:0] m_md;

    logic [BPP-1:0] cap_pix   [VT][HT];
    logic           cap_blank [VT][HT];
    logic           cap_hs    [VT][HT];
    logic           cap_vs    [VT][HT];
    int             vis_cnt   [VT];

    lcd_linebuf #(
        .H(H), .V(V), .BPP(BPP), .LINES(LINES), .VREP(VREP),
        .HFP(HFP), .HS(HS), .HBP(HBP), .VFP(VFP), .VS(VS), .VBP(VBP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .din(din), .mode(mode),
        .ce_pix(ce_pix), .lcd_on(lcd_on), .hs(hs), .vs(vs), .blank(blank),
        .pix(pix), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Track the raster and record outputs produced for each position
    always begin
        @(posedge clk);
        m_tick = ce_pix;
        m_rst  = !reset_n;
        m_md   = mode;
        #1;
        if (m_rst) begin
            mh = 0;
            mv = 0;
            m_prev = 2'b01;
        end else begin
            m_fs = (m_md != 2'b01) && (m_prev == 2'b01);
            m_prev = m_md;
            if (m_fs) begin
                mh = 0;
                mv = VT - VREP;
            end else if (m_tick) begin
                cap_pix[mv][mh]   = pix;
                cap_blank[mv][mh] = blank;
                cap_hs[mv][mh]    = hs;
                cap_vs[mv][mh]    = vs;
                if (mh == 0) vis_cnt[mv] = 0;
                if (blank == 1'b0) vis_cnt[mv] = vis_cnt[mv] + 1;
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ce_pix = ~ce_pix;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] val);
        ce_in = 1'b1;
        din   = val;
        step();
        ce_in = 1'b0;
    endtask

    task automatic wait_v(input int target);
        int n;
        n = 0;
        while (mv != target && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL wait_v%0d: got timeout expected raster line %0d", target, target);
        end
    endtask

    // Make the next clk edge one without a pixel tick
    task automatic align_no_tick();
        if (ce_pix) step();
    endtask

    initial begin
        vec_t vecs [24];
        logic [1:0] line0 [8];
        logic [1:0] line3 [10];
        line0 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        line3 = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
        //          v  h  pix blank hs vs
        vecs[0]  = '{0, 0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{0, 1, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{0, 3, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{0, 7, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1, 2, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1, 5, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2, 0, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2, 7, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3, 4, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4, 0, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4, 7, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{5, 3, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{6, 0, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{6, 7, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{7, 6, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{0, 8, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{0, 9, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{0, 10, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{0, 11, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{0, 12, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{8, 5, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{9, 0, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[22] = '{9, 11, 2'd0, 1'b1, 1'b1, 1'b1};
        vecs[23] = '{7, 13, 2'd0, 1'b1, 1'b0, 1'b0};

        // Reset
        reset_n = 1'b0;
        mode    = 2'b01;
        repeat (3) step();
        check("rst_hs", 32'(hs), 32'd0);
        check("rst_vs", 32'(vs), 32'd0);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_pix", 32'(pix), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Release reset together with frame start on a non-tick edge
        align_no_tick();
        reset_n = 1'b1;
        mode    = 2'b10;
        step();
        mode = 2'b11;
        step();
        // Source line 0
        foreach (line0[i]) wr(line0[i]);
        mode = 2'b00; step();
        mode = 2'b10; step();
        // Source line 1: 7 strobes, the 8th coincides with the next line start
        mode = 2'b11;
        repeat (7) wr(2'd3);
        mode = 2'b00; step();
        mode = 2'b10;
        wr(2'd3);
        // Source line 2 starts at index 0
        mode = 2'b11;
        for (int i = 0; i < 8; i++) wr((i % 2 == 0) ? 2'd1 : 2'd2);
        mode = 2'b00; step();
        mode = 2'b10; step();
        // Source line 3 with two excess strobes
        mode = 2'b11;
        foreach (line3[i]) wr(line3[i]);
        mode = 2'b00; step();
        // Complete line 3 only after source line 0 has been replayed
        wait_v(2);
        mode = 2'b10; step();
        wait_v(5);
        lcd_on = 1'b0;
        wait_v(6);
        lcd_on = 1'b1;
        wait_v(10);

        foreach (vecs[i]) begin
            check($sformatf("vec%0d_pix", i),   32'(cap_pix[vecs[i].v][vecs[i].h]),   32'(vecs[i].pix));
            check($sformatf("vec%0d_blank", i), 32'(cap_blank[vecs[i].v][vecs[i].h]), 32'(vecs[i].blank));
            check($sformatf("vec%0d_hs", i),    32'(cap_hs[vecs[i].v][vecs[i].h]),    32'(vecs[i].hs));
            check($sformatf("vec%0d_vs", i),    32'(cap_vs[vecs[i].v][vecs[i].h]),    32'(vecs[i].vs));
        end
        for (int h = 0; h < 8; h++) begin
            check($sformatf("lcdoff_pix_h%0d", h),   32'(cap_pix[5][h]),   32'd0);
            check($sformatf("lcdoff_blank_h%0d", h), 32'(cap_blank[5][h]), 32'd0);
        end
        for (int v = 0; v < 4; v++) check($sformatf("vis_cnt_v%0d", v), 32'(vis_cnt[v]), 32'd8);
        check("vis_cnt_v8", 32'(vis_cnt[8]), 32'd0);
        check("underrun_frame1", 32'(underrun), 32'd0);

        // New frame with writes stalled
        mode = 2'b01; step(); step();
        align_no_tick();
        mode = 2'b10;
        step();
        wait_v(1);
        for (int h = 0; h < 8; h++) begin
`ifdef LCD_UNDERRUN_EN
            check($sformatf("stall_pix_h%0d", h), 32'(cap_pix[0][h]), 32'd0);
`else
            check($sformatf("stall_pix_h%0d", h), 32'(cap_pix[0][h]), 32'(line0[h]));
`endif
            check($sformatf("stall_blank_h%0d", h), 32'(cap_blank[0][h]), 32'd0);
        end
`ifdef LCD_UNDERRUN_EN
        check("stall_underrun", 32'(underrun), 32'd1);
`else
        check("stall_underrun", 32'(underrun), 32'd0);
`endif
        // Resume writes; the flag is sticky
        mode = 2'b11;
        repeat (8) wr(2'd1);
        mode = 2'b00; step();
        mode = 2'b10; step();
        repeat (4) step();
`ifdef LCD_UNDERRUN_EN
        check("resume_underrun", 32'(underrun), 32'd1);
`else
        check("resume_underrun", 32'(underrun), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
